// File: rtl/dispatch1_4_pkg.sv
// Shared definitions for the 1-to-4 dispatcher.
//   ARCH_WIDTH      : default datapath width
//   NUM_PORTS       : number of output ports
//   PORT_A..PORT_D  : port-index constants for producers driving in_sel
//   port_onehot()   : decode a port index into a one-hot port mask
package dispatch1_4_pkg;

  localparam int unsigned ARCH_WIDTH = 64;
  localparam int unsigned NUM_PORTS  = 4;

  typedef logic [1:0] port_idx_t;

  localparam port_idx_t PORT_A = 2'd0;
  localparam port_idx_t PORT_B = 2'd1;
  localparam port_idx_t PORT_C = 2'd2;
  localparam port_idx_t PORT_D = 2'd3;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t idx);
    logic [NUM_PORTS-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/dispatch_slot.sv
// One-entry holding slot: a valid flag plus a data register.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : drop the held item at the next edge
//   load, load_data  : write a new item (wins over a same-cycle pop)
//   pop              : consumer takes the held item
//   valid, data      : slot state; data holds its last value while empty
module dispatch_slot #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      // A refill on the same edge as a pop keeps the slot full.
      valid <= 1'b1;
      data  <= load_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dispatch1_4.sv
// 1-to-4 dispatcher: steers each accepted input item into the one-entry
// slot of the port named by in_sel; each port drains independently.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : discard all held items; no accept this cycle
//   in_valid/in_ready/in_sel/in_data : producer handshake and payload
//   out_valid[3:0], out_ready[3:0]   : per-port consumer handshake
//   out_data_a..d   : payloads of ports 0..3
//   busy            : any port holds an item
module dispatch1_4
  import dispatch1_4_pkg::*;
#(
  parameter int unsigned WIDTH = ARCH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [1:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic [NUM_PORTS-1:0] out_valid,
  output logic [WIDTH-1:0]     out_data_a,
  output logic [WIDTH-1:0]     out_data_b,
  output logic [WIDTH-1:0]     out_data_c,
  output logic [WIDTH-1:0]     out_data_d,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic                 busy
);

  logic                 accept;
  logic [NUM_PORTS-1:0] load;
  logic [NUM_PORTS-1:0] pop;
  logic [WIDTH-1:0]     slot_data [NUM_PORTS];

  // Ready only depends on the selected slot: empty, or draining this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !flush) begin
      in_ready = !out_valid[in_sel] || out_ready[in_sel];
    end
  end

  assign accept = in_valid && in_ready;
  assign load   = accept ? port_onehot(in_sel) : '0;
  assign pop    = out_valid & out_ready;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
    dispatch_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (load[k]),
      .load_data(in_data),
      .pop      (pop[k]),
      .valid    (out_valid[k]),
      .data     (slot_data[k])
    );
  end

  assign out_data_a = slot_data[PORT_A];
  assign out_data_b = slot_data[PORT_B];
  assign out_data_c = slot_data[PORT_C];
  assign out_data_d = slot_data[PORT_D];
  assign busy       = |out_valid;

endmodule

// File: tb/tb_dispatch1_4.sv
// Scoreboard bench for dispatch1_4: accepted items are queued per port,
// a monitor pops and compares on every out_valid & out_ready transfer,
// and directed checks cover reset, latency, backpressure, flush and mixes.
module tb_dispatch1_4;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [1:0]   in_sel;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [3:0]   out_valid;
  logic [W-1:0] out_data_a, out_data_b, out_data_c, out_data_d;
  logic [3:0]   out_ready;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] dout [4];

  assign dout[0] = out_data_a;
  assign dout[1] = out_data_b;
  assign dout[2] = out_data_c;
  assign dout[3] = out_data_d;

  dispatch1_4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data_a(out_data_a),
    .out_data_b(out_data_b),
    .out_data_c(out_data_c),
    .out_data_d(out_data_d),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Record accepted items; reset and flush discard everything outstanding.
  always @(negedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else if (in_valid && in_ready) begin
      exp_q[in_sel].push_back(in_data);
    end
  end

  // Monitor: every transfer must match the oldest item queued for that port.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          n_cmp++;
          if (exp_q[k].size() == 0) begin
            n_bad++;
            $display("FAIL pop_port%0d: got unexpected item %0h expected none", k, dout[k]);
          end else begin
            logic [W-1:0] e;
            e = exp_q[k].pop_front();
            if (dout[k] !== e) begin
              n_bad++;
              $display("FAIL pop_port%0d: got %0h expected %0h", k, dout[k], e);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 64'h55;
    out_ready = 4'b0000;

    // Reset held two cycles with an item offered.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {60'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_data_a", out_data_a, 64'd0);
    check("rst_data_d", out_data_d, 64'd0);
    next_cycle();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_out_valid", {60'd0, out_valid}, 64'd0);

    // Latency: accept on port 2, visible next cycle.
    next_cycle();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 64'hDEAD_BEEF;
    @(negedge clk);
    check("lat_in_ready", {63'd0, in_ready}, 64'd1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_out_valid", {60'd0, out_valid}, 64'h4);
    check("lat_data_c", out_data_c, 64'hDEAD_BEEF);
    check("lat_busy", {63'd0, busy}, 64'd1);
    next_cycle();
    out_ready = 4'b0100;
    next_cycle();
    out_ready = 4'b0000;
    @(negedge clk);
    check("lat_drained", {60'd0, out_valid}, 64'd0);

    // Backpressure on port 1.
    next_cycle();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 64'h11;
    next_cycle();
    in_data = 64'h22;
    @(negedge clk);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    next_cycle();
    @(negedge clk);
    check("bp_hold_valid", {60'd0, out_valid}, 64'h2);
    check("bp_hold_data", out_data_b, 64'h11);
    next_cycle();
    out_ready = 4'b0010;
    @(negedge clk);
    check("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
    next_cycle();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    @(negedge clk);
    check("bp_refill_valid", {60'd0, out_valid}, 64'h2);
    check("bp_refill_data", out_data_b, 64'h22);

    // Throughput: 8 back-to-back items to port 3, drained every cycle.
    next_cycle();
    out_ready = 4'b1000;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_sel = 2'd3; in_data = 64'(i);
      @(negedge clk);
      check("tput_in_ready", {63'd0, in_ready}, 64'd1);
      if (i > 1) check("tput_valid", {63'd0, out_valid[3]}, 64'd1);
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("tput_valid_last", {63'd0, out_valid[3]}, 64'd1);
    next_cycle();
    out_ready = 4'b0000;
    @(negedge clk);
    check("tput_empty", {63'd0, out_valid[3]}, 64'd0);

    // Flush with ports 0 and 2 full (port 1 still holds 0x22).
    next_cycle();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 64'hA0;
    next_cycle();
    in_sel = 2'd2; in_data = 64'hC0;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_pre_valid", {60'd0, out_valid}, 64'h7);
    next_cycle();
    flush = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 64'hFF; out_ready = 4'b1111;
    @(negedge clk);
    check("fl_in_ready", {63'd0, in_ready}, 64'd0);
    next_cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    @(negedge clk);
    check("fl_out_valid", {60'd0, out_valid}, 64'd0);
    check("fl_busy", {63'd0, busy}, 64'd0);
    check("fl_data_a_held", out_data_a, 64'hA0);

    // Mixed: port 0 pops while port 1 accepts.
    next_cycle();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 64'h01;
    next_cycle();
    in_sel = 2'd1; in_data = 64'h02; out_ready = 4'b0001;
    @(negedge clk);
    check("mix_in_ready", {63'd0, in_ready}, 64'd1);
    next_cycle();
    in_valid = 1'b0; out_ready = 4'b0000;
    @(negedge clk);
    check("mix_out_valid", {60'd0, out_valid}, 64'h2);
    check("mix_data_b", out_data_b, 64'h02);
    next_cycle();
    out_ready = 4'b0010;
    next_cycle();
    out_ready = 4'b0000;

    // Mid-stream reset drops held and offered items.
    in_valid = 1'b1; in_sel = 2'd3; in_data = 64'h33;
    next_cycle();
    rst = 1'b1; in_data = 64'h44;
    @(negedge clk);
    check("mrst_in_ready", {63'd0, in_ready}, 64'd0);
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", {60'd0, out_valid}, 64'd0);
    check("mrst_data_d", out_data_d, 64'd0);

    // Drain: nothing may appear; all queues must be empty.
    next_cycle();
    out_ready = 4'b1111;
    repeat (2) next_cycle();
    @(negedge clk);
    for (int k = 0; k < 4; k++) check("end_queue_empty", 64'(exp_q[k].size()), 64'd0);
    check("end_out_valid", {60'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispatch1_4.md
DISPATCH1_4 -- requirements
Module: dispatch1_4

Interface
REQ-001 The module SHALL have parameter WIDTH, default `ARCH_WIDTH (64), the data width of every data bus.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The module SHALL have port flush, input, 1 bit: synchronous discard of all buffered items.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the producer offers an item.
REQ-006 The module SHALL have port in_sel, input, 2 bits: destination port index 0..3.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: item payload.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the item is accepted this cycle when in_valid and in_ready are both high.
REQ-009 The module SHALL have port out_valid, output, 4 bits: bit k high means port k holds an item.
REQ-010 The module SHALL have ports out_data_a, out_data_b, out_data_c, out_data_d, output, WIDTH bits each: payloads of ports 0..3.
REQ-011 The module SHALL have port out_ready, input, 4 bits: bit k high means the consumer on port k takes its item this cycle.
REQ-012 The module SHALL have port busy, output, 1 bit: OR of out_valid.

Function
REQ-013 Each port SHALL own a one-entry slot consisting of a valid flag and a WIDTH-bit data register.
REQ-014 in_ready SHALL equal !flush && (!out_valid[in_sel] || out_ready[in_sel]), computed combinationally with no dependence on in_valid.
REQ-015 On acceptance, slot[in_sel] SHALL load in_data and set valid at the next edge, giving 1-cycle latency.
REQ-016 Only slot[in_sel] SHALL be written; the other three slots keep their contents.
REQ-017 Slot k SHALL clear valid at the edge where out_valid[k] && out_ready[k], unless it is refilled at the same edge.
REQ-018 Simultaneous pop and accept on the same port SHALL leave valid set with the new data, so a port sustains 1 item/cycle.
REQ-019 Pops on different ports and an accept SHALL all take effect in the same cycle, independently.
REQ-020 out_data_x SHALL hold its last value while its valid is low; consumers ignore it.
REQ-021 flush SHALL clear all four valid flags at the next edge; an item offered in the flush cycle is not accepted (in_ready = 0); out_ready during flush has no effect.
REQ-022 Items to the same port SHALL be delivered in acceptance order; no ordering is guaranteed across ports.
REQ-023 Out-of-range select SHALL be impossible (2-bit index); no error output.

Reset
REQ-024 When rst is high at an edge, out_valid SHALL become 4'b0000, busy 0, and all data registers 0.
REQ-025 rst SHALL take priority over flush, accept and pop; an item offered during reset is dropped.
REQ-026 in_ready SHALL read 0 while rst is high.
REQ-027 Reset mid-stream SHALL discard all slot contents with no partial delivery afterward.

Structure
REQ-028 ARCH_WIDTH SHALL come from include/riscv64/common.vh.
REQ-029 The port-index constants (PORT_A=2'd0 .. PORT_D=2'd3) SHALL be added to common.vh for shared use by producers.
REQ-030 The one-entry slot SHALL be the sub-module dispatch_slot (ports clk, rst, flush, load, load_data, pop, valid, data), instantiated four times.
REQ-031 No latches SHALL be inferred; all combinational cases SHALL carry defaults.

Verification
REQ-032 Reset test: rst high 2 cycles with in_valid=1 -> out_valid=0000, in_ready=0, data=0; after release in_ready=1.
REQ-033 Latency test: accept sel=2, data=64'hDEAD_BEEF at cycle N -> out_valid=0100 and out_data_c=DEAD_BEEF at cycle N+1.
REQ-034 Backpressure test: port 1 full with out_ready[1]=0, offer sel=1 -> in_ready=0, slot unchanged; raise out_ready[1] -> same-cycle accept, new data visible next cycle.
REQ-035 Throughput test: 8 back-to-back items to port 3 with out_ready[3]=1 -> 8 consecutive valid cycles, data in order 1..8.
REQ-036 Flush test: ports 0 and 2 full, flush=1 with in_valid=1 sel=0 -> next cycle out_valid=0000 and the offered item is not accepted.
REQ-037 Mixed test: port 0 pops while an item is accepted for port 1 in the same cycle -> next cycle out_valid=0010, port 0 empty.
